// File: rtl/mips_alu_muldiv.sv
// Execute-stage ALU: combinational single-cycle ops plus an iterative 32-step mul/div engine writing HI/LO.
// Mul/div latency is 33 cycles from the Start edge to Done; Busy stalls the PC and Start is ignored while Busy.
module mips_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ALU_In,
    input  logic [4:0]       Shamt,
    input  logic             Start,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_t;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;

    assign add_res = ReadData1 + ALU_In;
    assign sub_res = ReadData1 - ALU_In;

    always_comb begin
        ALUResult = '0;
        Overflow  = 1'b0;
        case (ALUControl)
            OP_AND:  ALUResult = ReadData1 & ALU_In;
            OP_OR:   ALUResult = ReadData1 | ALU_In;
            OP_XOR:  ALUResult = ReadData1 ^ ALU_In;
            OP_NOR:  ALUResult = ~(ReadData1 | ALU_In);
            OP_ADD: begin
                ALUResult = add_res;
                Overflow  = (ReadData1[WIDTH-1] == ALU_In[WIDTH-1]) &&
                            (add_res[WIDTH-1] != ReadData1[WIDTH-1]);
            end
            OP_SUB: begin
                ALUResult = sub_res;
                Overflow  = (ReadData1[WIDTH-1] != ALU_In[WIDTH-1]) &&
                            (sub_res[WIDTH-1] != ReadData1[WIDTH-1]);
            end
            OP_SLL:  ALUResult = ALU_In << Shamt;
            OP_SRL:  ALUResult = ALU_In >> Shamt;
            OP_SRA:  ALUResult = $unsigned($signed(ALU_In) >>> Shamt);
            OP_SLT:  ALUResult = {{(WIDTH-1){1'b0}}, $signed(ReadData1) < $signed(ALU_In)};
            OP_SLTU: ALUResult = {{(WIDTH-1){1'b0}}, ReadData1 < ALU_In};
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

    // ------------------------------------------------------------------
    // Mul/div engine
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Shared work register: multiply keeps the product here with the
    // multiplier draining out of the low half; divide keeps remainder
    // in the high half and dividend/quotient in the low half.
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               start_muldiv;
    logic               start_div;
    logic               start_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_fixed;
    logic [WIDTH-1:0]   quo_raw, rem_raw;

    assign start_muldiv = (ALUControl == OP_MULT) || (ALUControl == OP_MULTU) ||
                          (ALUControl == OP_DIV)  || (ALUControl == OP_DIVU);
    assign start_div    = (ALUControl == OP_DIV)  || (ALUControl == OP_DIVU);
    assign start_signed = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);

    assign a_neg = start_signed & ReadData1[WIDTH-1];
    assign b_neg = start_signed & ALU_In[WIDTH-1];
    assign a_mag = a_neg ? -ReadData1 : ReadData1;
    assign b_mag = b_neg ? -ALU_In : ALU_In;

    assign mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    // The remainder stays below the divisor, so the difference fits in WIDTH bits.
    assign div_diff  = div_shift[WIDTH-1:0] - opb_q;

    assign mul_fixed = neg_res_q ? -work_q : work_q;
    assign quo_raw   = work_q[WIDTH-1:0];
    assign rem_raw   = work_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start && start_muldiv) begin
                    state_d   = ST_CALC;
                    cnt_d     = '0;
                    is_div_d  = start_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = (ALU_In == '0);
                    if (start_div) begin
                        work_d = {{WIDTH{1'b0}}, a_mag};
                        opb_d  = b_mag;
                    end else begin
                        work_d = {{WIDTH{1'b0}}, b_mag};
                        opb_d  = a_mag;
                    end
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    work_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                              work_q[WIDTH-2:0], div_ge};
                end else begin
                    work_d = {mul_sum, work_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    lo_d = div0_q ? '1 : (neg_res_q ? -quo_raw : quo_raw);
                    hi_d = neg_rem_q ? -rem_raw : rem_raw;
                end else begin
                    hi_d = mul_fixed[2*WIDTH-1:WIDTH];
                    lo_d = mul_fixed[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Directed bench for mips_alu_muldiv: ALU vectors, mul/div results and latency, hazards, reset abort.
module tb_mips_alu_muldiv;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_RSVD  = 4'b1111;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  ALUControl;
    logic [31:0] ReadData1;
    logic [31:0] ALU_In;
    logic [4:0]  Shamt;
    logic        Start;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Overflow;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_alu_muldiv #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ALUControl (ALUControl),
        .ReadData1  (ReadData1),
        .ALU_In     (ALU_In),
        .Shamt      (Shamt),
        .Start      (Start),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Overflow   (Overflow),
        .Busy       (Busy),
        .Done       (Done),
        .HI         (HI),
        .LO         (LO)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh,
                           input logic [31:0] eres, input logic eovf);
        @(negedge clk);
        ALUControl = op;
        ReadData1  = a;
        ALU_In     = b;
        Shamt      = sh;
        #1;
        chk(tag, ALUResult, eres);
        chk({tag, ".ovf"}, {31'b0, Overflow}, {31'b0, eovf});
        chk({tag, ".zero"}, {31'b0, Zero}, {31'b0, (eres == 32'h0)});
    endtask

    // Caller is at a negedge; the following posedge samples Start.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUControl = op;
        ReadData1  = a;
        ALU_In     = b;
        Start      = 1'b1;
    endtask

    // mode 1: re-assert Start with new operands mid-CALC; mode 2: evaluate ADD while Busy.
    task automatic wait_done(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                             input int mode);
        int cyc;
        cyc = 0;
        @(negedge clk);
        Start = 1'b0;
        chk({tag, ".busy_start"}, {31'b0, Busy}, 32'h1);
        while (Busy && cyc < 100) begin
            cyc++;
            if (mode == 1 && cyc == 5) begin
                ALUControl = OP_DIVU;
                ReadData1  = 32'd100;
                ALU_In     = 32'd7;
                Start      = 1'b1;
            end
            if (mode == 1 && cyc == 6) Start = 1'b0;
            if (mode == 2 && cyc == 10) begin
                ALUControl = OP_ADD;
                ReadData1  = 32'd3;
                ALU_In     = 32'd4;
                #1;
                chk({tag, ".add_busy"}, ALUResult, 32'd7);
                chk({tag, ".busy_mid"}, {31'b0, Busy}, 32'h1);
            end
            @(negedge clk);
        end
        chk({tag, ".latency"}, cyc, 32'd33);
        chk({tag, ".done"}, {31'b0, Done}, 32'h1);
        chk({tag, ".hi"}, HI, ehi);
        chk({tag, ".lo"}, LO, elo);
    endtask

    task automatic done_drops(input string tag);
        @(negedge clk);
        chk({tag, ".done_pulse"}, {31'b0, Done}, 32'h0);
    endtask

    initial begin
        int ndone;
        int nbusy;
        reset_n    = 1'b0;
        ALUControl = OP_AND;
        ReadData1  = '0;
        ALU_In     = '0;
        Shamt      = '0;
        Start      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy", {31'b0, Busy}, 32'h0);
        chk("rst.done", {31'b0, Done}, 32'h0);
        chk("rst.hi", HI, 32'h0);
        chk("rst.lo", LO, 32'h0);
        reset_n = 1'b1;

        alu_vec("add_ovf",  OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1);
        alu_vec("sub_zero", OP_SUB,  32'd5,        32'd5,        5'd0,  32'h00000000, 1'b0);
        alu_vec("sub_ovf",  OP_SUB,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1);
        alu_vec("slt",      OP_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0);
        alu_vec("sltu",     OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0);
        alu_vec("sra",      OP_SRA,  32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0);
        alu_vec("srl",      OP_SRL,  32'h0,        32'h80000000, 5'd4,  32'h08000000, 1'b0);
        alu_vec("sll",      OP_SLL,  32'h0,        32'h00000001, 5'd31, 32'h80000000, 1'b0);
        alu_vec("and",      OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0);
        alu_vec("or",       OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0);
        alu_vec("xor",      OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0);
        alu_vec("nor",      OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1'b0);
        alu_vec("mult_code",OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0,  32'h00000000, 1'b0);
        alu_vec("rsvd",     OP_RSVD, 32'h12345678, 32'h1,        5'd0,  32'h00000000, 1'b0);
        chk("alu.hi", HI, 32'h0);
        chk("alu.lo", LO, 32'h0);

        @(negedge clk);
        launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done("mult", 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        done_drops("mult");

        @(negedge clk);
        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu", 32'hFFFFFFFE, 32'h00000001, 0);
        done_drops("multu");

        @(negedge clk);
        launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        done_drops("div_neg");

        @(negedge clk);
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done("divu", 32'd2, 32'd14, 0);
        done_drops("divu");

        @(negedge clk);
        launch(OP_DIV, 32'h00001234, 32'h0);
        wait_done("div0", 32'h00001234, 32'hFFFFFFFF, 0);
        done_drops("div0");

        @(negedge clk);
        launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_min", 32'h00000000, 32'h80000000, 0);
        done_drops("div_min");

        // Start with a non-mul/div code must not launch anything.
        @(negedge clk);
        launch(OP_ADD, 32'd1, 32'd1);
        @(negedge clk);
        Start = 1'b0;
        chk("start_alu.busy", {31'b0, Busy}, 32'h0);

        // Restart attempt mid-CALC, then back-to-back launch on the Done cycle.
        @(negedge clk);
        launch(OP_MULTU, 32'h00010000, 32'h00010000);
        wait_done("restart", 32'h00000001, 32'h00000000, 1);
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done("b2b", 32'd2, 32'd14, 2);
        done_drops("b2b");

        @(negedge clk);
        launch(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done("div_negb", 32'd1, 32'hFFFFFFFD, 0);
        done_drops("div_negb");

        // Reset abort around cycle 10 of a MULT.
        @(negedge clk);
        launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort.busy_before", {31'b0, Busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("abort.busy", {31'b0, Busy}, 32'h0);
        chk("abort.done", {31'b0, Done}, 32'h0);
        chk("abort.hi", HI, 32'h0);
        chk("abort.lo", LO, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) ndone++;
            if (Busy) nbusy++;
        end
        chk("abort.no_done", ndone, 32'd0);
        chk("abort.no_busy", nbusy, 32'd0);
        chk("abort.lo_after", LO, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
